// File: rtl/air_con_pkg.sv
`default_nettype none
// ============================================================================
// Module   : air_con_pkg
// Purpose  : Definitions shared by the air-conditioner fan blocks. These are
//            the distance bus width, the obstacle stop threshold used by the
//            motor controller, and the range-finder FSM state encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package air_con_pkg;

  // Distance bus width (cm) and motor stop threshold (distance <= 5 cm).
  localparam int DIST_W       = 10;
  localparam int DIST_STOP_CM = 5;

  // Range-finder FSM state encodings.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    TRIG      = ST_TRIG,
    WAIT_RISE = ST_WAIT_RISE,
    MEASURE   = ST_MEASURE,
    DONE      = ST_DONE
  } rf_state_t;

endpackage
`default_nettype wire

// File: rtl/us_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : us_tick_gen
// Purpose  : Produces a one-cycle tick once per microsecond, derived from the
//            system clock. CLK_FREQ_HZ must be a multiple of 1 MHz.
// Ports    : clk     in  1  system clock
//            reset   in  1  asynchronous, active-high reset
//            us_tick out 1  one-cycle pulse every CLK_FREQ_HZ/1e6 clocks
// Revision : 1.0 - initial release
// ============================================================================
module us_tick_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic us_tick
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;

  // With DIV == 1 the counter sits at 0 and the tick stays high after the
  // first cycle out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      us_tick <= 1'b0;
    end else if (div_cnt == CW'(DIV - 1)) begin
      div_cnt <= '0;
      us_tick <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      us_tick <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ultrasonic_range_finder.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_range_finder
// Purpose  : Drives an HC-SR04-class ultrasonic sensor. The block fires a
//            trigger pulse every measurement period and times the echo pulse.
//            It converts the echo time to centimetres (floor(us/US_PER_CM)) and
//            publishes a registered distance with a one-cycle valid strobe.
// Ports    : clk        in   1       system clock
//            reset      in   1       asynchronous, active-high reset
//            echo       in   1       sensor echo, asynchronous to clk
//            trig       out  1       sensor trigger
//            distance   out  DIST_W  last measured distance in cm, held
//            dist_valid out  1       one-cycle strobe when distance updates
//            timeout    out  1       last measurement timed out
// Revision : 1.0 - initial release
// ============================================================================
module ultrasonic_range_finder
  import air_con_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int TRIG_US         = 10,
  parameter int MEAS_PERIOD_US  = 60_000,
  parameter int ECHO_TIMEOUT_US = 25_000,
  parameter int US_PER_CM       = 58,
  parameter int DIST_MAX_CM     = 400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              dist_valid,
  output logic              timeout
);

  localparam int US_MAX = (TRIG_US > ECHO_TIMEOUT_US) ? TRIG_US : ECHO_TIMEOUT_US;
  localparam int US_W   = $clog2(US_MAX + 1);
  localparam int PER_W  = (MEAS_PERIOD_US > 1) ? $clog2(MEAS_PERIOD_US) : 1;
  localparam int SUB_W  = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam logic [DIST_W-1:0] DIST_MAX = DIST_W'(DIST_MAX_CM);

  // --------------------------------------------------------------------------
  // Microsecond timebase
  // --------------------------------------------------------------------------
  logic us_tick;

  us_tick_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_us_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .us_tick (us_tick)
  );

  // --------------------------------------------------------------------------
  // Echo synchronizer and edge detect. Edges come from the synchronized copy
  // only, so the raw pin never reaches the FSM.
  // --------------------------------------------------------------------------
  logic echo_meta;
  logic echo_sync;
  logic echo_prev;
  logic echo_rise;
  logic echo_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_meta <= 1'b0;
      echo_sync <= 1'b0;
      echo_prev <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
      echo_prev <= echo_sync;
    end
  end

  assign echo_rise = echo_sync & ~echo_prev;
  assign echo_fall = ~echo_sync & echo_prev;

  // --------------------------------------------------------------------------
  // Free-running measurement period counter; its wrap is the start event.
  // --------------------------------------------------------------------------
  logic [PER_W-1:0] per_cnt;
  logic             start_evt;

  assign start_evt = us_tick && (per_cnt == PER_W'(MEAS_PERIOD_US - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt <= '0;
    end else if (us_tick) begin
      if (start_evt) per_cnt <= '0;
      else           per_cnt <= per_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  rf_state_t         state;
  rf_state_t         state_next;
  logic [US_W-1:0]   us_cnt;
  logic [SUB_W-1:0]  sub_cnt;
  logic [DIST_W-1:0] cm_cnt;
  logic              tmo_cause;

  logic us_clr;
  logic us_inc;
  logic meas_clr;
  logic meas_inc;
  logic cause_set;
  logic cause_val;
  logic done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    trig       = 1'b0;
    us_clr     = 1'b0;
    us_inc     = 1'b0;
    meas_clr   = 1'b0;
    meas_inc   = 1'b0;
    cause_set  = 1'b0;
    cause_val  = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: begin
        if (start_evt) begin
          state_next = TRIG;
          us_clr     = 1'b1;
        end
      end

      TRIG: begin
        trig = 1'b1;
        if (us_tick) begin
          if (us_cnt == US_W'(TRIG_US - 1)) begin
            state_next = WAIT_RISE;
            us_clr     = 1'b1;
          end else begin
            us_inc = 1'b1;
          end
        end
      end

      WAIT_RISE: begin
        if (echo_rise) begin
          state_next = MEASURE;
          meas_clr   = 1'b1;
          us_clr     = 1'b1;
        end else if (us_tick) begin
          if (us_cnt == US_W'(ECHO_TIMEOUT_US - 1)) begin
            state_next = DONE;
            cause_set  = 1'b1;
            cause_val  = 1'b1;
          end else begin
            us_inc = 1'b1;
          end
        end
      end

      MEASURE: begin
        // The tick in the falling-edge cycle still counts. The echo is high
        // for exactly one tick per cycle that the synchronized level was high.
        meas_inc = us_tick;
        if (echo_fall) begin
          state_next = DONE;
          cause_set  = 1'b1;
          cause_val  = 1'b0;
        end else if (us_tick) begin
          if (us_cnt == US_W'(ECHO_TIMEOUT_US - 1)) begin
            state_next = DONE;
            cause_set  = 1'b1;
            cause_val  = 1'b1;
          end else begin
            us_inc = 1'b1;
          end
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      us_cnt <= '0;
    end else if (us_clr) begin
      us_cnt <= '0;
    end else if (us_inc) begin
      us_cnt <= us_cnt + 1'b1;
    end
  end

  // Sub-cm counter divides the microsecond ticks by US_PER_CM. The cm count
  // saturates so that a long echo cannot wrap into a small distance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_cnt <= '0;
      cm_cnt  <= '0;
    end else if (meas_clr) begin
      sub_cnt <= '0;
      cm_cnt  <= '0;
    end else if (meas_inc) begin
      if (sub_cnt == SUB_W'(US_PER_CM - 1)) begin
        sub_cnt <= '0;
        if (cm_cnt < DIST_MAX) cm_cnt <= cm_cnt + 1'b1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          tmo_cause <= 1'b0;
    else if (cause_set) tmo_cause <= cause_val;
  end

  // --------------------------------------------------------------------------
  // Result registers: distance, timeout and the strobe change together.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      distance   <= '0;
      timeout    <= 1'b0;
      dist_valid <= 1'b0;
    end else begin
      dist_valid <= done;
      if (done) begin
        timeout <= tmo_cause;
        if (tmo_cause || (cm_cnt > DIST_MAX)) distance <= DIST_MAX;
        else                                  distance <= cm_cnt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_range_finder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ultrasonic_range_finder
// Purpose  : Directed, table-driven bench for ultrasonic_range_finder. It runs
//            with a 1 MHz clock (one us tick per clock) and a shortened
//            period, timeout and distance clamp, so each measurement takes
//            only a few thousand cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_range_finder;

  localparam int P        = 2000;  // measurement period, us
  localparam int TRIG     = 10;
  localparam int TMO      = 900;
  localparam int DMAX     = 12;    // 12 cm = 696 us, below the 900 us timeout
  localparam int N_VEC    = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       echo = 1'b0;
  logic       trig;
  logic [9:0] distance;
  logic       dist_valid;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  ultrasonic_range_finder #(
    .CLK_FREQ_HZ     (1_000_000),
    .TRIG_US         (TRIG),
    .MEAS_PERIOD_US  (P),
    .ECHO_TIMEOUT_US (TMO),
    .US_PER_CM       (58),
    .DIST_MAX_CM     (DMAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .echo       (echo),
    .trig       (trig),
    .distance   (distance),
    .dist_valid (dist_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int width;     // echo high time in us; 0 = no echo
    bit stuck;     // echo held high from before the trigger
    int exp_dist;
    bit exp_tmo;
  } vec_t;

  vec_t vecs [N_VEC];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts sampled cycles until trig is seen high.
  task automatic wait_trig_high(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      step();
      n++;
      if (trig) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Counts sampled cycles with trig high (including the first one seen).
  task automatic wait_trig_low(output int n, output bit ok);
    n  = 1;
    ok = 1'b0;
    for (int i = 0; i < 4 * TRIG; i++) begin
      step();
      if (!trig) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      step();
      if (dist_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    bit ok;
    int held;
    if (v.stuck) echo = 1'b1;
    wait_trig_high(n, ok);
    check({name, "_trig_seen"}, int'(ok), 1);
    wait_trig_low(n, ok);
    check({name, "_trig_width"}, n, TRIG);
    repeat (5) step();
    if (!v.stuck && v.width > 0) begin
      echo = 1'b1;
      repeat (v.width) step();
      echo = 1'b0;
    end
    wait_valid(ok);
    check({name, "_valid_seen"}, int'(ok), 1);
    check({name, "_distance"}, int'(distance), v.exp_dist);
    check({name, "_timeout"}, int'(timeout), int'(v.exp_tmo));
    held = int'(distance);
    step();
    check({name, "_strobe_1cyc"}, int'(dist_valid), 0);
    check({name, "_held"}, int'(distance), held);
    echo = 1'b0;
  endtask

  initial begin
    int  n;
    int  vcnt;
    bit  ok;

    vecs[0]  = '{width: 580,  stuck: 1'b0, exp_dist: 10,   exp_tmo: 1'b0};
    vecs[1]  = '{width: 290,  stuck: 1'b0, exp_dist: 5,    exp_tmo: 1'b0};
    vecs[2]  = '{width: 347,  stuck: 1'b0, exp_dist: 5,    exp_tmo: 1'b0};
    vecs[3]  = '{width: 30,   stuck: 1'b0, exp_dist: 0,    exp_tmo: 1'b0};
    vecs[4]  = '{width: 57,   stuck: 1'b0, exp_dist: 0,    exp_tmo: 1'b0};
    vecs[5]  = '{width: 58,   stuck: 1'b0, exp_dist: 1,    exp_tmo: 1'b0};
    vecs[6]  = '{width: 0,    stuck: 1'b0, exp_dist: DMAX, exp_tmo: 1'b1};
    vecs[7]  = '{width: 406,  stuck: 1'b0, exp_dist: 7,    exp_tmo: 1'b0};
    vecs[8]  = '{width: 696,  stuck: 1'b0, exp_dist: DMAX, exp_tmo: 1'b0};
    vecs[9]  = '{width: 800,  stuck: 1'b0, exp_dist: DMAX, exp_tmo: 1'b0};
    vecs[10] = '{width: 0,    stuck: 1'b1, exp_dist: DMAX, exp_tmo: 1'b1};

    // Reset state
    repeat (3) step();
    check("rst_trig", int'(trig), 0);
    check("rst_distance", int'(distance), 0);
    check("rst_valid", int'(dist_valid), 0);
    check("rst_timeout", int'(timeout), 0);
    reset = 1'b0;

    // First trigger comes at the first period wrap.
    wait_trig_high(n, ok);
    check("first_trig_delay", n, P + 1);
    wait_trig_low(n, ok);
    check("first_trig_width", n, TRIG);

    for (int i = 0; i < N_VEC; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted in the middle of MEASURE.
    wait_trig_high(n, ok);
    wait_trig_low(n, ok);
    repeat (5) step();
    echo = 1'b1;
    repeat (100) step();
    reset = 1'b1;
    #1;
    check("midrst_trig", int'(trig), 0);
    check("midrst_distance", int'(distance), 0);
    check("midrst_valid", int'(dist_valid), 0);
    check("midrst_timeout", int'(timeout), 0);
    echo = 1'b0;
    step();
    step();
    reset = 1'b0;
    n    = 0;
    vcnt = 0;
    ok   = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      step();
      n++;
      if (dist_valid) vcnt++;
      if (trig) begin
        ok = 1'b1;
        break;
      end
    end
    check("postrst_trig_delay", n, P + 1);
    check("postrst_no_valid", vcnt, 0);
    wait_trig_low(n, ok);
    repeat (5) step();
    echo = 1'b1;
    repeat (580) step();
    echo = 1'b0;
    wait_valid(ok);
    check("postrst_valid_seen", int'(ok), 1);
    check("postrst_distance", int'(distance), 10);
    check("postrst_timeout", int'(timeout), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
